// File: rtl/dff_share_arbiter_pkg.sv
// Shared definitions for the dff_share_arbiter block: FSM state encoding
// and default parameter values used by the top, interface and bench.
package dff_share_arbiter_pkg;

  // IDLE: nobody holds the register. OWNED: exactly one grant bit is set.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_N        = 4;
  localparam int unsigned DEFAULT_WIDTH    = 8;
  localparam int unsigned DEFAULT_IDX_W    = 2;
  localparam int unsigned DEFAULT_MAX_HOLD = 4;

endpackage

// File: rtl/dff_share_arbiter_if.sv
// Request/grant/data bundle between N requesting sequencers and the shared
// register block.
//   req   : per-requester level-held request
//   d_in  : flattened write data, requester i at [i*WIDTH +: WIDTH]
//   gnt   : one-hot grant (zero when idle)
//   owner : index of current owner (zero when idle)
//   busy  : a grant is active
//   q/qbar: shared register value and its complement
interface dff_share_arbiter_if
  import dff_share_arbiter_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = DEFAULT_IDX_W
);
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] d_in;
  logic [N-1:0]       gnt;
  logic [IDX_W-1:0]   owner;
  logic               busy;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   qbar;

  modport master (output req, d_in, input gnt, owner, busy, q, qbar);
  modport slave  (input req, d_in, output gnt, owner, busy, q, qbar);
endinterface

// File: rtl/dff_share_arbiter_rr_pick.sv
// Combinational round-robin winner finder.
//   req_i     : request vector
//   start_i   : index where the search begins (wraps modulo N)
//   excl_i    : index to skip when excl_en_i is set
//   excl_en_i : enable for the exclusion
//   valid_o   : some eligible request was found
//   idx_o     : first eligible index at or after start_i
module dff_share_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic [IDX_W-1:0] excl_i,
  input  logic             excl_en_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  int               cand_s;
  logic [IDX_W-1:0] cand_idx_s;

  // Scan offsets from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    valid_o    = 1'b0;
    idx_o      = '0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_s = int'(start_i) + k;
      if (cand_s >= N) begin
        cand_s = cand_s - N;
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = IDX_W'(cand_s);
      if (req_i[cand_idx_s] && !(excl_en_i && (cand_idx_s == excl_i))) begin
        valid_o = 1'b1;
        idx_o   = cand_idx_s;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/dff_share_arbiter.sv
// Shares one WIDTH-bit D register (Q/QBAR) between N requesters using
// round-robin arbitration with a bounded hold time while others wait.
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset
//   bus    : request/data in, grant/owner/busy/q/qbar out (slave modport)
module dff_share_arbiter
  import dff_share_arbiter_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int IDX_W    = DEFAULT_IDX_W,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input logic                clk_i,
  input logic                rst_ni,
  dff_share_arbiter_if.slave bus
);

  localparam int HCNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0]  q_q, qbar_q;

  logic [IDX_W-1:0]  nxt_ptr_s;
  logic [IDX_W-1:0]  pick_start_s;
  logic              pick_excl_en_s;
  logic              pick_valid_s;
  logic [IDX_W-1:0]  pick_idx_s;
  logic [N-1:0]      pick_onehot_s;
  logic              owner_req_s;
  logic              others_s;
  logic              wr_s;
  logic [WIDTH-1:0]  wr_data_s;

  assign nxt_ptr_s   = (owner_q == IDX_W'(N - 1)) ? '0 : owner_q + IDX_W'(1);
  assign owner_req_s = bus.req[owner_q];
  // gnt_q is one-hot on the owner while OWNED, so this is "someone else waits".
  assign others_s    = |(bus.req & ~gnt_q);
  assign wr_data_s   = bus.d_in[owner_q*WIDTH +: WIDTH];

  // While owned, the next winner is searched from owner+1 with the owner excluded,
  // which serves both the release and the expiry handover.
  assign pick_start_s   = (state_q == ST_OWNED) ? nxt_ptr_s : ptr_q;
  assign pick_excl_en_s = (state_q == ST_OWNED);

  dff_share_arbiter_rr_pick #(.N(N), .IDX_W(IDX_W)) u_rr_pick (
    .req_i     (bus.req),
    .start_i   (pick_start_s),
    .excl_i    (owner_q),
    .excl_en_i (pick_excl_en_s),
    .valid_o   (pick_valid_s),
    .idx_o     (pick_idx_s)
  );

  // One-hot form of the search result.
  always_comb begin
    pick_onehot_s             = '0;
    pick_onehot_s[pick_idx_s] = 1'b1;
  end

  // Next-state, grant and hold-counter logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    wr_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d = ST_OWNED;
          gnt_d   = pick_onehot_s;
          owner_d = pick_idx_s;
          hcnt_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWNED: begin
        if (!owner_req_s) begin
          // Release: no write, hand over in the same edge if anyone waits.
          ptr_d  = nxt_ptr_s;
          hcnt_d = '0;
          if (pick_valid_s) begin
            gnt_d   = pick_onehot_s;
            owner_d = pick_idx_s;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            owner_d = '0;
          end
        end else begin
          wr_s = 1'b1;
          if ((hcnt_q == HCNT_MAX) && others_s) begin
            // Hold expired: final write still lands, then rotate.
            ptr_d   = nxt_ptr_s;
            hcnt_d  = '0;
            gnt_d   = pick_onehot_s;
            owner_d = pick_idx_s;
          end else if (hcnt_q != HCNT_MAX) begin
            hcnt_d = hcnt_q + HCNT_W'(1);
          end else begin
            hcnt_d = hcnt_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        owner_d = '0;
        ptr_d   = '0;
        hcnt_d  = '0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Shared storage flop; QBAR is kept as its own register of the complement.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q    <= '0;
      qbar_q <= '1;
    end else if (wr_s) begin
      q_q    <= wr_data_s;
      qbar_q <= ~wr_data_s;
    end else begin
      q_q    <= q_q;
      qbar_q <= qbar_q;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == ST_OWNED);
  assign bus.q     = q_q;
  assign bus.qbar  = qbar_q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Self-checking bench for dff_share_arbiter: directed scenarios plus random
// traffic compared against a cycle-level behavioural model of the arbiter.
module tb_dff_share_arbiter;
  import dff_share_arbiter_pkg::*;

  localparam int N        = DEFAULT_N;
  localparam int WIDTH    = DEFAULT_WIDTH;
  localparam int IDX_W    = DEFAULT_IDX_W;
  localparam int MAX_HOLD = DEFAULT_MAX_HOLD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Model: current owner (-1 idle), rotation pointer, writes in this tenure, Q.
  int             m_owner;
  int             m_ptr;
  int             m_writes;
  logic [WIDTH-1:0] m_q;

  always #5 clk = ~clk;

  dff_share_arbiter_if #(.N(N), .WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  dff_share_arbiter #(.N(N), .WIDTH(WIDTH), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  function automatic int rr_search(logic [N-1:0] r, int start, int excl);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (start + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] e;
    e = '0;
    if (m_owner >= 0) e[m_owner] = 1'b1;
    return e;
  endfunction

  function automatic logic [IDX_W-1:0] exp_owner();
    return (m_owner < 0) ? '0 : IDX_W'(m_owner);
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = 0;
    m_writes = 0;
    m_q      = '0;
  endtask

  // Applies one clock edge worth of rules to the model using current inputs.
  task automatic model_edge();
    logic [N-1:0] others;
    if (!rst_n) begin
      model_reset();
    end else if (m_owner < 0) begin
      m_owner  = rr_search(bus.req, m_ptr, -1);
      m_writes = 0;
    end else if (!bus.req[m_owner]) begin
      m_ptr    = (m_owner + 1) % N;
      m_owner  = rr_search(bus.req, m_ptr, m_owner);
      m_writes = 0;
    end else begin
      m_q = bus.d_in[m_owner*WIDTH +: WIDTH];
      m_writes++;
      others = bus.req;
      others[m_owner] = 1'b0;
      if (m_writes >= MAX_HOLD && others != '0) begin
        m_ptr    = (m_owner + 1) % N;
        m_owner  = rr_search(bus.req, m_ptr, m_owner);
        m_writes = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst_n   = 1'b0;
    model_reset();
    tick();
    #4;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req  = 4'b1111;
    bus.d_in = {$urandom()};
    rst_n    = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      bus.d_in = {$urandom()};
      checks++;
      if (bus.q !== 8'h00 || bus.qbar !== 8'hFF || bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold c=%0d q=%h qbar=%h gnt=%b busy=%b want 00 ff 0000 0", c, bus.q, bus.qbar, bus.gnt, bus.busy);
      end
      #4;
      checks++;
      if (bus.q !== 8'h00 || bus.gnt !== 4'b0000 || bus.owner !== 2'd0) begin
        failures++;
        $display("FAIL reset_midcycle c=%0d q=%h gnt=%b owner=%0d want 00 0000 0", c, bus.q, bus.gnt, bus.owner);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_arb gnt=%b owner=%0d busy=%b want 0001 0 1", bus.gnt, bus.owner, bus.busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.d_in = {$urandom()};
    bus.d_in[2*WIDTH +: WIDTH] = 8'hA5;
    bus.req = 4'b0100;
    tick();
    checks++;
    if (bus.gnt !== 4'b0100 || bus.owner !== 2'd2 || bus.busy !== 1'b1 || bus.q !== 8'h00) begin
      failures++;
      $display("FAIL single_grant gnt=%b owner=%0d busy=%b q=%h want 0100 2 1 00", bus.gnt, bus.owner, bus.busy, bus.q);
    end
    tick();
    checks++;
    if (bus.q !== 8'hA5 || bus.qbar !== 8'h5A) begin
      failures++;
      $display("FAIL single_write q=%h qbar=%h want a5 5a", bus.q, bus.qbar);
    end
    bus.req = 4'b0000;
    bus.d_in[2*WIDTH +: WIDTH] = 8'h11;
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.owner !== 2'd0 || bus.q !== 8'hA5) begin
      failures++;
      $display("FAIL single_release gnt=%b busy=%b owner=%0d q=%h want 0000 0 0 a5", bus.gnt, bus.busy, bus.owner, bus.q);
    end
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 1, 3, 0};
    logic [N-1:0] want;
    do_reset();
    bus.req = 4'b1011;
    for (int c = 0; c < 16; c++) begin
      bus.d_in = {$urandom()};
      tick();
      want = '0;
      want[order[c/4]] = 1'b1;
      checks++;
      if (bus.gnt !== want || bus.q !== m_q) begin
        failures++;
        $display("FAIL rr_order c=%0d gnt=%b q=%h want %b %h", c, bus.gnt, bus.q, want, m_q);
      end
    end
  endtask

  task automatic test_early_release();
    logic [WIDTH-1:0] last;
    do_reset();
    bus.req = 4'b1010;
    bus.d_in = {$urandom()};
    tick();
    checks++;
    if (bus.gnt !== 4'b0010) begin
      failures++;
      $display("FAIL early_grant gnt=%b want 0010", bus.gnt);
    end
    bus.d_in = {$urandom()};
    tick();
    bus.d_in = {$urandom()};
    last = bus.d_in[1*WIDTH +: WIDTH];
    tick();
    bus.req = 4'b1000;
    bus.d_in[1*WIDTH +: WIDTH] = ~last;
    tick();
    checks++;
    if (bus.gnt !== 4'b1000 || bus.busy !== 1'b1 || bus.owner !== 2'd3 || bus.q !== last) begin
      failures++;
      $display("FAIL early_handover gnt=%b busy=%b owner=%0d q=%h want 1000 1 3 %h", bus.gnt, bus.busy, bus.owner, bus.q, last);
    end
    bus.d_in[3*WIDTH +: WIDTH] = 8'h6E;
    tick();
    checks++;
    if (bus.q !== 8'h6E) begin
      failures++;
      $display("FAIL early_new_owner_write q=%h want 6e", bus.q);
    end
  endtask

  task automatic test_no_competition();
    logic [WIDTH-1:0] want;
    do_reset();
    bus.req = 4'b0001;
    tick();
    for (int c = 0; c < 10; c++) begin
      bus.d_in = {$urandom()};
      want = bus.d_in[WIDTH-1:0];
      tick();
      checks++;
      if (bus.gnt !== 4'b0001 || bus.q !== want) begin
        failures++;
        $display("FAIL solo c=%0d gnt=%b q=%h want 0001 %h", c, bus.gnt, bus.q, want);
      end
    end
    // Hold counter is saturated: a newcomer takes over after one more write.
    bus.req = 4'b0011;
    bus.d_in = {$urandom()};
    want = bus.d_in[WIDTH-1:0];
    tick();
    checks++;
    if (bus.gnt !== 4'b0010 || bus.q !== want) begin
      failures++;
      $display("FAIL solo_saturated_expiry gnt=%b q=%h want 0010 %h", bus.gnt, bus.q, want);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0100;
    bus.d_in = {$urandom()};
    bus.d_in[2*WIDTH +: WIDTH] = 8'h3C;
    tick();
    tick();
    checks++;
    if (bus.gnt !== 4'b0100 || bus.q !== 8'h3C) begin
      failures++;
      $display("FAIL midreset_setup gnt=%b q=%h want 0100 3c", bus.gnt, bus.q);
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.q !== 8'h00 || bus.qbar !== 8'hFF || bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async q=%h qbar=%h gnt=%b busy=%b want 00 ff 0000 0", bus.q, bus.qbar, bus.gnt, bus.busy);
    end
    #1;
    rst_n = 1'b1;
    bus.req = 4'b1111;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0 || bus.q !== 8'h00) begin
      failures++;
      $display("FAIL midreset_restart gnt=%b owner=%0d q=%h want 0001 0 00", bus.gnt, bus.owner, bus.q);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom());
      bus.d_in = {$urandom()};
      tick();
      checks++;
      if (bus.gnt !== exp_gnt() || bus.owner !== exp_owner() || bus.busy !== (m_owner >= 0) ||
          bus.q !== m_q || bus.qbar !== ~m_q) begin
        failures++;
        $display("FAIL random c=%0d gnt=%b owner=%0d busy=%b q=%h qbar=%h want %b %0d %b %h %h",
                 c, bus.gnt, bus.owner, bus.busy, bus.q, bus.qbar, exp_gnt(), exp_owner(), (m_owner >= 0), m_q, ~m_q);
      end
    end
  endtask

  initial begin
    bus.req  = '0;
    bus.d_in = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_no_competition();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_share_arbiter.md
Name: dff_share_arbiter

Overview:
- Shares one WIDTH-bit D-type storage register (Q/QBAR pair) between N requesters.
- Rotating-priority (round-robin) arbitration with a bounded hold time.
- Only the owner may write the register; Q and QBAR are the shared outputs.
- Sits between requesting sequencers and the common state register; the storage flop is instantiated inside this block.

Parameters:
- N, 4: number of requesters.
- WIDTH, 8: register data width.
- IDX_W, 2: owner index width; must satisfy 2**IDX_W >= N.
- MAX_HOLD, 4: maximum consecutive grant cycles while other requests are pending; must be >= 1.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
- REQ  input  N  per-requester request, level-held.
- D_IN  input  N*WIDTH  flattened write data; requester i occupies bits [i*WIDTH +: WIDTH].
- GNT  output  N  one-hot registered grant; all zero when idle.
- OWNER  output  IDX_W  index of the current owner; 0 when idle.
- BUSY  output  1  high while any grant is active.
- Q  output  WIDTH  shared register value.
- QBAR  output  WIDTH  always ~Q.

Behaviour:
- Reset (RESET=0, asynchronous): Q=0, QBAR=all ones, GNT=0, OWNER=0, BUSY=0, state=IDLE, PTR=0, HCNT=0. All outputs are registered.
- States: IDLE (no owner) and OWNED (exactly one GNT bit set). BUSY equals (state==OWNED).
- Winner search: first i with REQ[i]=1, scanning PTR, PTR+1, ... modulo N. The search runs combinationally; its result is registered into GNT/OWNER.
- IDLE: if REQ!=0, then on the next edge GNT=onehot(winner), OWNER=winner, HCNT=0, state=OWNED. If REQ==0, remain in IDLE.
  - Latency: REQ high before edge k gives GNT at edge k.
- OWNED, owner o, REQ[o]=1: each edge writes Q<=D_IN[o], QBAR<=~D_IN[o]. The first write occurs at the edge after GNT rises.
- OWNED, release (REQ[o]=0):
  - No write at this edge.
  - PTR<=o+1 mod N.
  - If other requests are pending, GNT moves to the winner found from o+1 at the same edge (no idle bubble) and HCNT=0.
  - Otherwise GNT=0 and state=IDLE.
- OWNED, expiry (REQ[o]=1, HCNT==MAX_HOLD-1, and some REQ[j]=1 with j!=o):
  - The write from o still happens at this edge.
  - GNT moves to the winner searched from o+1, excluding o.
  - PTR<=o+1 mod N, HCNT=0.
- OWNED, REQ[o]=1, no expiry: HCNT increments and saturates at MAX_HOLD-1. An owner with no competition keeps the grant indefinitely.
- Q holds its value whenever no write occurs (IDLE, or the release edge).
- Simultaneous requests: round-robin order only; there is no fixed priority after the first arbitration from PTR=0.
- Reset mid-operation: immediate return to reset values, including Q. No partial write.
- REQ bits for indices >= N do not exist; bits in D_IN of non-owners are ignored.

Decomposition:
- Shared package: state encodings (ST_IDLE=1'b0, ST_OWNED=1'b1), DEFAULT_N, DEFAULT_WIDTH, DEFAULT_MAX_HOLD.
- One natural sub-module, rr_pick: combinational round-robin winner finder.
  - Inputs: request vector, start pointer, exclude index, exclude enable.
  - Outputs: valid, index.
- Storage register, HCNT and FSM stay in the top module.

Test Plan:
- Reset: drive RESET=0 with REQ=4'b1111 -> Q=8'h00, QBAR=8'hFF, GNT=0, BUSY=0 at all times while RESET=0; async check mid-cycle.
- Single requester: REQ=4'b0100, D_IN[2]=8'hA5 -> GNT=4'b0100 after 1 edge, OWNER=2, Q=8'hA5/QBAR=8'h5A one edge later; drop REQ -> GNT=0 next edge, Q stays 8'hA5.
- Round-robin: REQ=4'b1011 held, MAX_HOLD=4 -> grant order 0,1,3,0,..., each owner for exactly 4 cycles; Q tracks the owner's D_IN.
- Early release handover: owner 1 drops REQ after 2 cycles while REQ[3]=1 -> GNT goes 0010->1000 at the same edge, no idle cycle, and Q does not load D_IN[1] on the release edge.
- No competition: only REQ[0] held for 10 cycles -> GNT=4'b0001 throughout, HCNT saturates, and Q updates every edge.
- Reset mid-grant: owner 2 writing 8'h3C, RESET pulsed low for half a cycle -> Q=0, GNT=0 immediately; after release, arbitration restarts from PTR=0.
